// File: rtl/pk_unpack.sv
// Public-key unpacker: latches a packed key, exposes rho and streams the 10-bit t1
// coefficients one per handshake. Define PK_UNPACK_SHIFT_D_EN to emit t1 << D instead of t1.
module pk_unpack #(
  parameter int K         = 6,
  parameter int N         = 256,
  parameter int D         = 13,
  parameter int SEEDBYTES = 32,
  localparam int PK_BITS  = 8 * (SEEDBYTES + K * N * 10 / 8)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               in_rts,
  output logic               in_rtr,
  input  logic [PK_BITS-1:0] linear_pk,
  output logic [255:0]       rho,
  output logic [22:0]        coeff,
  output logic [2:0]         coeff_row,
  output logic [7:0]         coeff_idx,
  output logic               last,
  output logic               out_rts,
  input  logic               out_rtr
);

  localparam int T1_BITS = PK_BITS - 256;

  typedef enum logic {IDLE, STREAM} state_t;

  state_t             state;
  logic [T1_BITS-1:0] sr;
  logic [2:0]         next_row;
  logic [7:0]         next_idx;

  always_comb begin
    next_row = coeff_row;
    next_idx = coeff_idx + 8'd1;
    if (coeff_idx == 8'(N - 1)) begin
      next_idx = '0;
      next_row = coeff_row + 3'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      sr        <= '0;
      rho       <= '0;
      coeff_row <= '0;
      coeff_idx <= '0;
      last      <= 1'b0;
      out_rts   <= 1'b0;
      in_rtr    <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (in_rts) begin
            sr        <= linear_pk[PK_BITS-1:256];
            rho       <= linear_pk[255:0];
            coeff_row <= '0;
            coeff_idx <= '0;
            last      <= (K * N == 1);
            out_rts   <= 1'b1;
            in_rtr    <= 1'b0;
            state     <= STREAM;
          end
        end
        STREAM: begin
          if (out_rtr) begin
            sr <= {10'b0, sr[T1_BITS-1:10]};
            if (last) begin
              coeff_row <= '0;
              coeff_idx <= '0;
              last      <= 1'b0;
              out_rts   <= 1'b0;
              in_rtr    <= 1'b1;
              state     <= IDLE;
            end else begin
              coeff_row <= next_row;
              coeff_idx <= next_idx;
              last      <= (next_row == 3'(K - 1)) && (next_idx == 8'(N - 1));
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef PK_UNPACK_SHIFT_D_EN
  assign coeff = 23'(sr[9:0]) << D;
`else
  assign coeff = {13'b0, sr[9:0]};
`endif

endmodule

// File: tb/tb_pk_unpack.sv
// Scoreboard bench for pk_unpack: stimulus pushes expected coefficients, a monitor
// pops and compares on each output transfer and checks stability during stalls.
module tb_pk_unpack;

  localparam int K       = 6;
  localparam int N       = 256;
  localparam int KN      = K * N;
  localparam int PK_BITS = 8 * (32 + K * N * 10 / 8);

  typedef struct {
    logic [22:0] coeff;
    logic [2:0]  row;
    logic [7:0]  idx;
    logic        last;
  } exp_t;

  logic               clock = 1'b0;
  logic               reset = 1'b1;
  logic               in_rts = 1'b0;
  logic               in_rtr;
  logic [PK_BITS-1:0] linear_pk = '0;
  logic [255:0]       rho;
  logic [22:0]        coeff;
  logic [2:0]         coeff_row;
  logic [7:0]         coeff_idx;
  logic               last;
  logic               out_rts;
  logic               out_rtr = 1'b1;

  pk_unpack #(.K(K), .N(N), .D(13), .SEEDBYTES(32)) dut (
    .clock(clock), .reset(reset), .in_rts(in_rts), .in_rtr(in_rtr),
    .linear_pk(linear_pk), .rho(rho), .coeff(coeff), .coeff_row(coeff_row),
    .coeff_idx(coeff_idx), .last(last), .out_rts(out_rts), .out_rtr(out_rtr)
  );

  always #5 clock = ~clock;

  int   checks = 0;
  int   errors = 0;
  int   xfers  = 0;
  int   lasts  = 0;
  int   cyc    = 0;
  int   last_cyc = -10;
  bit   bp_en  = 1'b0;
  exp_t q[$];

  initial forever begin
    @(posedge clock);
    cyc++;
  end

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [22:0] scale(input logic [9:0] t1);
`ifdef PK_UNPACK_SHIFT_D_EN
    return {t1, 13'b0};
`else
    return {13'b0, t1};
`endif
  endfunction

  // mode 0: slice from key bit stream; 1: four leading ones; 2: field-boundary pattern
  task automatic push_key(input logic [PK_BITS-1:0] pk, input int mode);
    exp_t e;
    logic [9:0] t1;
    for (int c = 0; c < KN; c++) begin
      case (mode)
        1:       t1 = (c < 4) ? 10'd1 : 10'd0;
        2:       t1 = (c == 0) ? 10'h3FF : (c == 255) ? 10'h3FC : 10'h000;
        default: t1 = pk[256 + 10*c +: 10];
      endcase
      e.coeff = scale(t1);
      e.row   = 3'(c / N);
      e.idx   = 8'(c % N);
      e.last  = (c == KN - 1);
      q.push_back(e);
    end
  endtask

  // Monitor
  initial begin
    bit   prev_stall = 1'b0;
    exp_t held, e;
    forever begin
      @(negedge clock);
      if (reset) begin
        prev_stall = 1'b0;
      end else begin
        if (in_rtr && out_rts) chk("rtr_rts_overlap", 1, 0);
        if (prev_stall && out_rts) begin
          chk("stall_coeff", coeff, held.coeff);
          chk("stall_row",   coeff_row, held.row);
          chk("stall_idx",   coeff_idx, held.idx);
          chk("stall_last",  last, held.last);
        end
        if (out_rts && out_rtr) begin
          if (q.size() == 0) begin
            chk("unexpected_xfer", 1, 0);
          end else begin
            e = q.pop_front();
            chk("coeff", coeff, e.coeff);
            chk("row",   coeff_row, e.row);
            chk("idx",   coeff_idx, e.idx);
            chk("last",  last, e.last);
          end
          xfers++;
          if (last) begin
            lasts++;
            last_cyc = cyc;
          end
        end
        prev_stall = out_rts && !out_rtr;
        held.coeff = coeff; held.row = coeff_row; held.idx = coeff_idx; held.last = last;
      end
    end
  end

  initial forever begin
    @(posedge clock);
    #1;
    out_rtr = bp_en ? ($urandom_range(0, 3) != 0) : 1'b1;
  end

  task automatic load_key(input logic [PK_BITS-1:0] pk, input bit chk_gap);
    bit ok = 1'b0;
    int ld_cyc = 0;
    @(posedge clock); #1;
    linear_pk = pk;
    in_rts    = 1'b1;
    for (int n = 0; n < 6000; n++) begin
      @(negedge clock);
      if (in_rtr) begin
        ok = 1'b1;
        ld_cyc = cyc;
        break;
      end
    end
    chk("load_timeout", ok, 1);
    @(posedge clock); #1;
    in_rts = 1'b0;
    @(negedge clock);
    chk("rho_after_load", rho, pk[255:0]);
    chk("out_rts_after_load", out_rts, 1);
    chk("in_rtr_after_load", in_rtr, 0);
    if (chk_gap) chk("load_cycle_after_last", ld_cyc, last_cyc + 1);
  endtask

  task automatic drain(input string name);
    bit ok = 1'b0;
    for (int n = 0; n < 12000; n++) begin
      @(negedge clock);
      if (q.size() == 0 && in_rtr) begin
        ok = 1'b1;
        break;
      end
    end
    chk(name, ok, 1);
  endtask

  task automatic rand_key(output logic [PK_BITS-1:0] pk);
    for (int i = 0; i < PK_BITS / 32; i++) pk[32*i +: 32] = $urandom;
  endtask

  initial begin
    logic [PK_BITS-1:0] pk, pk2;
    int base, base_last;
    bit ok;

    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    chk("rst_in_rtr", in_rtr, 1);
    chk("rst_out_rts", out_rts, 0);
    chk("rst_rho", rho, 0);
    chk("rst_coeff", coeff, 0);
    chk("rst_last", last, 0);

    // Rho and basic decode, full unstalled stream
    pk = '0;
    for (int i = 0; i < 32; i++) pk[8*i +: 8] = 8'(i);
    pk[8*32 +: 8] = 8'h01; pk[8*33 +: 8] = 8'h04;
    pk[8*34 +: 8] = 8'h10; pk[8*35 +: 8] = 8'h40;
    push_key(pk, 1);
    base = xfers; base_last = lasts;
    load_key(pk, 0);
    chk("rho_byte0", rho[7:0], 8'h00);
    chk("rho_byte31", rho[255:248], 8'h1F);
    chk("rho_byte17", rho[143:136], 8'h11);
    drain("drain_basic");
    chk("full_xfer_count", xfers - base, KN);
    chk("full_last_count", lasts - base_last, 1);
    chk("in_rtr_after_last", cyc - last_cyc, 1);

    // Field boundary
    pk = '0;
    pk[8*32 +: 8] = 8'hFF; pk[8*33 +: 8] = 8'h03; pk[8*351 +: 8] = 8'hFF;
    push_key(pk, 2);
    load_key(pk, 0);
    drain("drain_boundary");

    // Backpressure
    rand_key(pk);
    push_key(pk, 0);
    bp_en = 1'b1;
    load_key(pk, 0);
    drain("drain_backpressure");
    bp_en = 1'b0;

    // Load while busy
    rand_key(pk);
    rand_key(pk2);
    push_key(pk, 0);
    load_key(pk, 0);
    push_key(pk2, 0);
    load_key(pk2, 1);
    drain("drain_busy");

    // Reset mid-stream
    rand_key(pk);
    push_key(pk, 0);
    load_key(pk, 0);
    base = xfers;
    ok = 1'b0;
    for (int n = 0; n < 2000; n++) begin
      @(negedge clock);
      if (xfers - base >= 100) begin
        ok = 1'b1;
        break;
      end
    end
    chk("reset_wait_timeout", ok, 1);
    @(posedge clock); #1 reset = 1'b1;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    q.delete();
    @(negedge clock);
    chk("midrst_in_rtr", in_rtr, 1);
    chk("midrst_out_rts", out_rts, 0);
    chk("midrst_rho", rho, 0);
    chk("midrst_coeff", coeff, 0);
    chk("midrst_row", coeff_row, 0);
    chk("midrst_idx", coeff_idx, 0);
    chk("midrst_last", last, 0);
    rand_key(pk);
    push_key(pk, 0);
    load_key(pk, 0);
    drain("drain_after_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
